// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// master = fetch side, slave = memory side.
interface if_fetch_stage_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: PC, imem handshake, IF/ID register, skid buffer, redirect.
// Define FETCH_PERF_CNT_EN to add stall/flush counters.
module if_fetch_stage #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PCWrite,
   input  logic            IF_ID_Write,
   input  logic            IF_Flush,
   input  logic [XLEN-1:0] branch_target,
   if_fetch_stage_if.master imem,
   output logic [XLEN-1:0] IF_ID_pc,
   output logic [XLEN-1:0] IF_ID_instr,
   output logic            IF_ID_valid,
   output logic            fetch_busy
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     stall_cycle_cnt,
   output logic [31:0]     flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_HOLD,
      S_KILL
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            valid;
   } if_id_t;

   localparam if_id_t BUBBLE = '{
      pc:    '0,
      instr: NOP_INSTR,
      valid: 1'b0
   };

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] redirect;
   logic            req;
   logic            busy;
   if_id_t          if_id;
   if_id_t          skid;

   wire             ack     = imem.imem_ack;
   wire [XLEN-1:0]  pc_next = pc + XLEN'(4);

   assign imem.imem_req  = req;
   assign imem.imem_addr = pc;

   assign IF_ID_pc    = if_id.pc;
   assign IF_ID_instr = if_id.instr;
   assign IF_ID_valid = if_id.valid;
   assign fetch_busy  = busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         pc       <= RESET_PC;
         redirect <= RESET_PC;
         req      <= 1'b0;
         busy     <= 1'b0;
         if_id    <= BUBBLE;
         skid     <= BUBBLE;
      end else if (IF_Flush) begin
         if_id <= BUBBLE;
         skid  <= BUBBLE;
         // an unanswered request must drain before the new PC goes out
         if ((state == S_WAIT || state == S_KILL) && !ack) begin
            redirect <= branch_target;
            state    <= S_KILL;
            req      <= 1'b1;
            busy     <= 1'b1;
         end else begin
            pc    <= branch_target;
            state <= S_FETCH;
            req   <= 1'b1;
            busy  <= 1'b0;
         end
      end else begin
         unique case (state)
            S_FETCH: begin
               if (IF_ID_Write)
                  if_id.valid <= 1'b0;
               if (IF_ID_Write)
                  if_id.instr <= NOP_INSTR;
               state <= S_WAIT;
               req   <= 1'b1;
               busy  <= 1'b1;
            end
            S_WAIT: begin
               if (ack && IF_ID_Write) begin
                  if_id <= '{
                     pc:    pc,
                     instr: imem.imem_rdata,
                     valid: 1'b1
                  };
                  if (PCWrite)
                     pc <= pc_next;
                  state <= S_FETCH;
                  req   <= 1'b1;
                  busy  <= 1'b0;
               end else if (ack) begin
                  skid <= '{
                     pc:    pc,
                     instr: imem.imem_rdata,
                     valid: 1'b1
                  };
                  state <= S_HOLD;
                  req   <= 1'b0;
                  busy  <= 1'b0;
               end else if (IF_ID_Write) begin
                  if_id.valid <= 1'b0;
                  if_id.instr <= NOP_INSTR;
               end
            end
            S_HOLD: begin
               if (IF_ID_Write) begin
                  if_id <= skid;
                  skid  <= BUBBLE;
                  if (PCWrite)
                     pc <= pc_next;
                  state <= S_FETCH;
                  req   <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            S_KILL: begin
               if (IF_ID_Write) begin
                  if_id.valid <= 1'b0;
                  if_id.instr <= NOP_INSTR;
               end
               // rdata of the killed request is dropped here
               if (ack) begin
                  pc    <= redirect;
                  state <= S_FETCH;
                  req   <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_FETCH;
               req   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycle_cnt <= '0;
         flush_cnt       <= '0;
      end else begin
         if (!IF_ID_Write && !IF_Flush && stall_cycle_cnt != '1)
            stall_cycle_cnt <= stall_cycle_cnt + 32'd1;
         if (IF_Flush && flush_cnt != '1)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Directly consumes the hazard unit's PCWrite, IF_ID_Write and IF_Flush, plus the branch target from EX.
- Produces IF_ID_pc / IF_ID_instr, which the decode stage and the hazard unit compare against.
- A skid buffer absorbs instructions returned while IF/ID is stalled; a redirect path handles branch flushes that arrive while a fetch is outstanding.

Parameters:
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, instruction written into IF/ID on reset or flush (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- PCWrite  input  1  from hazard unit; 0 = hold PC.
- IF_ID_Write  input  1  from hazard unit; 0 = hold IF/ID.
- IF_Flush  input  1  from hazard unit; taken branch, kill the fetch and redirect.
- branch_target  input  XLEN  redirect PC, sampled when IF_Flush=1.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  XLEN  fetch address; stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse: imem_rdata is valid.
- imem_rdata  input  XLEN  fetched instruction.
- IF_ID_pc  output  XLEN  PC of the instruction in IF/ID.
- IF_ID_instr  output  XLEN  instruction in IF/ID.
- IF_ID_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- fetch_busy  output  1  1 while in WAIT or KILL; decode sees bubbles.

Behaviour:
Reset (rst=1 at an edge):
- pc=RESET_PC, state=FETCH, imem_req=0.
- IF_ID_pc=0, IF_ID_instr=NOP_INSTR, IF_ID_valid=0.
- Skid buffer empty, redirect_pending=0.
- rst overrides every other input.

States:
- FETCH: imem_req=1, imem_addr=pc. Next cycle goes to WAIT.
- WAIT:
  - imem_req stays 1 with the address held.
  - On imem_ack with IF_ID_Write=1 and no flush: IF/ID <= {pc, imem_rdata, valid=1}; if PCWrite=1 then pc <= pc+4 (wraps modulo 2^XLEN); go to FETCH.
  - On imem_ack with IF_ID_Write=0: capture {pc, rdata} into the skid buffer; go to HOLD.
  - No ack: stay in WAIT. Every cycle here, IF_ID_Write=1 loads a bubble (IF_ID_valid=0, IF_ID_instr=NOP_INSTR).
- HOLD:
  - imem_req=0.
  - When IF_ID_Write=1: IF/ID <= skid contents with valid=1; pc advances if PCWrite=1; skid empties; go to FETCH.
- KILL:
  - Entered on IF_Flush while in WAIT with no ack in the same cycle.
  - imem_req stays 1 with the old address until imem_ack; that rdata is discarded.
  - Then pc <= redirect register; go to FETCH.
  - Further flushes in KILL overwrite the redirect register.

Flush (IF_Flush=1) has highest priority after rst and overrides PCWrite=0 and IF_ID_Write=0:
- IF/ID <= {0, NOP_INSTR, valid=0}.
- Skid buffer is cleared.
- From FETCH, HOLD, or WAIT with an ack in the same cycle: pc <= branch_target; go to FETCH.
- From WAIT with no ack: redirect register <= branch_target; go to KILL.

Stall and ordering rules:
- PCWrite=0 while IF_ID_Write=1 (not produced by the hazard unit): IF/ID loads, pc holds, and the same address is refetched.
- Latency: zero-wait memory (ack the cycle after the request) gives one instruction every 2 cycles.
- No instruction is ever dropped or duplicated except by a flush.
- IF_ID_pc increments by exactly 4 between consecutive valid instructions unless a flush intervenes.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds 32-bit outputs stall_cycle_cnt and flush_cnt, both reset to 0 by rst and saturating at 32'hFFFF_FFFF.
  - stall_cycle_cnt increments on every cycle with IF_ID_Write=0 and IF_Flush=0.
  - flush_cnt increments on every cycle with IF_Flush=1.
- Undefined: the ports and logic are absent; the rest of the block's behaviour is identical.

Test Plan:
- Reset, then zero-wait memory returning addr-based data -> IF_ID_pc sequence 0x0, 0x4, 0x8 with IF_ID_valid=1 every 2nd cycle.
- Memory acks during IF_ID_Write=0 held for 3 cycles -> HOLD entered, instruction at 0x8 appears in IF/ID the cycle after IF_ID_Write returns to 1, exactly once, next fetch at 0xC.
- IF_Flush=1 with branch_target=0x100 while in FETCH -> IF_ID_valid=0, IF_ID_instr=0x00000013, next imem_addr=0x100.
- IF_Flush=1 with target 0x200 while in WAIT, ack for 0x10 arrives 2 cycles later -> 0x10 data never reaches IF/ID, next imem_addr=0x200.
- rst asserted mid-WAIT and mid-HOLD -> next cycle imem_addr=RESET_PC, IF_ID_valid=0, skid empty; late ack from the old request is ignored.
- With FETCH_PERF_CNT_EN: 5 stall cycles and 2 flushes -> stall_cycle_cnt=5, flush_cnt=2.
